// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo: 8N1 UART receiver feeding a FIFO that is read out as an AXI-Stream master.
// Line idle after a byte closes a packet, so the final byte is held back until its last flag is known.
module uart_rx_axis_fifo #(
    parameter int CLK_RATE  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8,
    parameter int IDLE_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [DATA_BITS-1:0]     m_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_RATE / BAUD;
    localparam int IDLE_CLKS = IDLE_BITS * CPB;
    localparam int CW = $clog2(CPB + 1);
    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [IW-1:0] IDLE_END = IW'(IDLE_CLKS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic [1:0] rst_q;
    logic rst_n, rx_m, rxs, rxs_d;
    state_t state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_idx;
    logic [DATA_BITS-1:0] shift, hold_data;
    logic hold_full;
    logic [IW-1:0] idle_cnt;
    logic [DATA_BITS:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt_next;
    logic fall, done, tmo, push, pop, accept;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst)
        if (!rst) rst_q <= 2'b00;
        else rst_q <= {rst_q[0], 1'b1};

    assign rst_n = rst_q[1];
    assign fall = rxs_d & ~rxs;
    assign done = state == STOP && clk_cnt == BIT_END && rxs;
    assign tmo = state == IDLE && hold_full && idle_cnt == IDLE_END;
    assign push = (done & hold_full) | tmo;
    assign pop = m_axis_valid & m_axis_ready;
    assign accept = push & (fifo_count != FULL_CNT | pop);
    assign cnt_next = fifo_count + (AW + 1)'(accept) - (AW + 1)'(pop);
    assign m_axis_data = m_axis_valid ? mem[rd_ptr][DATA_BITS-1:0] : '0;
    assign m_axis_last = m_axis_valid & mem[rd_ptr][DATA_BITS];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_m, rxs, rxs_d} <= 3'b111;
        else {rx_m, rxs, rxs_d} <= {rx, rx_m, rxs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            clk_cnt <= clk_cnt + 1'b1;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (fall) state <= START;
                end
                START: if (clk_cnt == HALF_END) begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    state <= rxs ? IDLE : DATA;
                end
                DATA: if (clk_cnt == BIT_END) begin
                    clk_cnt <= '0;
                    shift[bit_idx] <= rxs;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) state <= STOP;
                end
                STOP: if (clk_cnt == BIT_END) begin
                    clk_cnt <= '0;
                    frame_err <= ~rxs;
                    state <= rxs ? IDLE : BREAK;
                end
                BREAK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A completed byte displaces the held one with last=0; an idle timeout flushes it with last=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            idle_cnt <= '0;
        end else begin
            if (done) {hold_full, hold_data} <= {1'b1, shift};
            else if (tmo) hold_full <= 1'b0;
            idle_cnt <= (done || (fall && state == IDLE)) ? '0 :
                        (state == IDLE && hold_full) ? idle_cnt + 1'b1 : idle_cnt;
        end
    end

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {tmo, hold_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            m_axis_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(accept);
            rd_ptr <= rd_ptr + AW'(pop);
            fifo_count <= cnt_next;
            m_axis_valid <= cnt_next != '0;
            overflow <= push & ~accept;
        end
    end
endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// tb_uart_rx_axis_fifo: drives UART frames into uart_rx_axis_fifo and checks the AXIS stream
// against packet lists built by the bench (bytes in order, last on each packet's final byte).
module tb_uart_rx_axis_fifo;
    localparam int CLK_RATE = 3200000;
    localparam int BAUD = 100000;
    localparam int CPB = CLK_RATE / BAUD;
    localparam int IDLE_BITS = 20;
    localparam int DEPTH = 8;
    localparam int IDLE_CLKS = IDLE_BITS * CPB;

    logic clk = 1'b0, rst = 1'b0, rx = 1'b1, m_axis_ready = 1'b0;
    logic [7:0] m_axis_data;
    logic m_axis_valid, m_axis_last, frame_err, overflow;
    logic [3:0] fifo_count;

    int tests = 0, fails = 0, cyc = 0;
    int ferr_n = 0, ovf_n = 0, stall_bad = 0;
    logic [8:0] got_q[$];
    int got_t[$];
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;

    uart_rx_axis_fifo #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .DATA_BITS(8), .DEPTH(DEPTH),
                        .IDLE_BITS(IDLE_BITS)) dut (
        .clk(clk), .rst(rst), .rx(rx), .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last), .frame_err(frame_err),
        .overflow(overflow), .fifo_count(fifo_count));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observe transfers, pulses and stall stability away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            if (m_axis_valid && m_axis_ready) begin
                got_q.push_back({m_axis_last, m_axis_data});
                got_t.push_back(cyc);
            end
            if (frame_err) ferr_n++;
            if (overflow) ovf_n++;
            if (pv && !pr && (!m_axis_valid || m_axis_data !== pd || m_axis_last !== pl)) stall_bad++;
        end
        pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data; pl = m_axis_last;
    end

    task automatic clear_obs();
        got_q.delete(); got_t.delete();
        ferr_n = 0; ovf_n = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic wait_n(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string name, input int idx, input logic [8:0] exp);
        logic [8:0] act;
        act = (idx < got_q.size()) ? got_q[idx] : 9'bx;
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got last/data %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [15:0] act;
        repeat (3) @(posedge clk);
        #1;
        act = {m_axis_valid, m_axis_last, m_axis_data, frame_err, overflow, fifo_count};
        tests++;
        if (act !== 16'h0) begin fails++; $display("FAIL reset_hold: outputs %h, expected 0", act); end
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        act = {m_axis_valid, m_axis_last, m_axis_data, frame_err, overflow, fifo_count};
        tests++;
        if (act !== 16'h0) begin fails++; $display("FAIL reset_release: outputs %h, expected 0", act); end
    endtask

    task automatic test_single();
        int t0, dt, lo;
        clear_obs();
        m_axis_ready = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        wait_n(1, IDLE_CLKS + 4 * CPB);
        check_int("single_count", got_q.size(), 1);
        check_entry("single", 0, {1'b1, 8'hA5});
        // Stop bit is sampled mid-bit (9.5 bit-times after the start edge) plus a few sync cycles.
        lo = 9 * CPB + CPB / 2 + IDLE_CLKS;
        dt = got_t.size() > 0 ? got_t[0] - t0 : -1;
        tests++;
        if (dt < lo || dt > lo + 6) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, expected %0d..%0d", dt, lo, lo + 6);
        end
        check_int("single_ferr", ferr_n, 0);
    endtask

    task automatic test_back_to_back();
        clear_obs();
        m_axis_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
        wait_n(3, IDLE_CLKS + 4 * CPB);
        for (int i = 0; i < 3; i++) check_entry("b2b", i, {i == 2, 8'(i + 1)});
        check_int("b2b_err_ovf", ferr_n + ovf_n, 0);
    endtask

    task automatic test_overflow();
        clear_obs();
        m_axis_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
        repeat (IDLE_CLKS + 2 * CPB) @(posedge clk);
        #1;
        check_int("ovf_count", int'(fifo_count), DEPTH);
        check_int("ovf_pulses", ovf_n, 1);
        m_axis_ready = 1'b1;
        wait_n(DEPTH, 100);
        for (int i = 0; i < DEPTH; i++) check_entry("ovf_drain", i, {1'b0, 8'(i)});
        repeat (20) @(posedge clk);
        #1;
        check_int("ovf_drained_size", got_q.size(), DEPTH);
        check_int("ovf_drained_count", int'(fifo_count), 0);
    endtask

    task automatic test_frame_err();
        clear_obs();
        m_axis_ready = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h3C, 1'b0);
        repeat (2 * CPB) @(posedge clk);
        #1;
        check_int("ferr_pulse", ferr_n, 1);
        send_byte(8'h55, 1'b1);
        wait_n(1, IDLE_CLKS + 4 * CPB);
        check_int("ferr_outputs", got_q.size(), 1);
        check_entry("ferr_next", 0, {1'b1, 8'h55});
        check_int("ferr_total", ferr_n, 1);
    endtask

    task automatic test_glitch();
        clear_obs();
        m_axis_ready = 1'b1;
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (IDLE_CLKS + 12 * CPB) @(posedge clk);
        #1;
        check_int("glitch_outputs", got_q.size(), 0);
        check_int("glitch_ferr", ferr_n, 0);
        check_int("glitch_count", int'(fifo_count), 0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] act;
        clear_obs();
        m_axis_ready = 1'b0;
        @(posedge clk); #1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (IDLE_CLKS + 2 * CPB) @(posedge clk);
        #1;
        check_int("rstmid_pre_count", int'(fifo_count), 2);
        rx = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        act = {m_axis_valid, m_axis_last, m_axis_data, frame_err, overflow, fifo_count};
        tests++;
        if (act !== 16'h0) begin fails++; $display("FAIL rstmid_async: outputs %h, expected 0", act); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send_byte(8'h7E, 1'b1);
        repeat (IDLE_CLKS + 2 * CPB) @(posedge clk);
        #1;
        check_int("rstmid_post_count", int'(fifo_count), 1);
        m_axis_ready = 1'b1;
        wait_n(1, 50);
        check_entry("rstmid_post", 0, {1'b1, 8'h7E});
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [7:0] b;
        int len;
        bit fin;
        clear_obs();
        fin = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int p = 0; p < 3; p++) begin
                    len = $urandom_range(1, 5);
                    for (int k = 0; k < len; k++) begin
                        b = 8'($urandom);
                        exp_q.push_back({k == len - 1, b});
                        send_byte(b, 1'b1);
                        if (k < len - 1) begin
                            repeat ($urandom_range(0, 8 * CPB)) @(posedge clk);
                            #1;
                        end
                    end
                    repeat (IDLE_CLKS + CPB) @(posedge clk);
                    #1;
                end
                fin = 1;
            end
            begin
                while (!fin) begin
                    @(posedge clk); #1;
                    m_axis_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_axis_ready = 1'b1;
        wait_n(exp_q.size(), 100);
        check_int("rand_size", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check_entry("rand", i, exp_q[i]);
        check_int("rand_err_ovf", ferr_n + ovf_n, 0);
    endtask

    task automatic test_stability();
        check_int("stall_stability", stall_bad, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        test_stability();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
